// File: rtl/sm3_pkg.sv
// Shared SM3 constants, FSM state type and the bit-level helper functions
// used by the iterative compression core.
package sm3_pkg;

  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [255:0] SM3_IV = {
    32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
    32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e
  };

  localparam word_t T_LO = 32'h79cc4519;
  localparam word_t T_HI = 32'h7a879d8a;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Rotating a doubled word keeps the result correct for n == 0 as well.
  function automatic word_t rotl32(input word_t x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic word_t p0(input word_t x);
    return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
  endfunction

  function automatic word_t p1(input word_t x);
    return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
  endfunction

  function automatic word_t ff_j(input word_t x, input word_t y, input word_t z,
                                 input logic hi);
    return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
  endfunction

  function automatic word_t gg_j(input word_t x, input word_t y, input word_t z,
                                 input logic hi);
    return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
  endfunction

endpackage

// File: rtl/sm3_round.sv
// One combinational SM3 compression round: working registers A..H packed
// with A in the top word, plus Wj, Wj+4 and the round index j.
module sm3_round
  import sm3_pkg::*;
(
  input  logic [255:0] state_in,
  input  logic [31:0]  w_j,
  input  logic [31:0]  w_j4,
  input  logic [5:0]   j,
  output logic [255:0] state_out
);

  word_t a, b, c, d, e, f, g, h;
  word_t t_j, a12, ss1, ss2, tt1, tt2;
  logic  hi;

  assign {a, b, c, d, e, f, g, h} = state_in;

  always_comb begin
    hi  = (j[5:4] != 2'b00);
    t_j = hi ? T_HI : T_LO;
    a12 = rotl32(a, 5'd12);
    // j[4:0] gives the mod-32 wrap of the constant rotation for j >= 32.
    ss1 = rotl32(a12 + e + rotl32(t_j, j[4:0]), 5'd7);
    ss2 = ss1 ^ a12;
    tt1 = ff_j(a, b, c, hi) + d + ss2 + (w_j ^ w_j4);
    tt2 = gg_j(e, f, g, hi) + h + ss1 + w_j;
    state_out = {tt1, a, rotl32(b, 5'd9), c,
                 p0(tt2), e, rotl32(f, 5'd19), g};
  end

endmodule

// File: rtl/sm3_cf_iter.sv
// Iterative SM3 compression function CF(V,B), one round per clock, answering
// the cf_start/cf_end four-phase handshake.
module sm3_cf_iter
  import sm3_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         cf_start,
  input  logic [255:0] v_in,
  input  logic [511:0] b_in,
  output logic [255:0] v_out,
  output logic         cf_end
);

  state_t       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [255:0] v_q, v_d;
  logic [255:0] abcd_q, abcd_d;
  logic [255:0] v_out_q, v_out_d;
  logic         cf_end_q, cf_end_d;
  word_t        w_q [16];
  word_t        w_d [16];
  word_t        w_load [16];
  word_t        w_shift [16];
  word_t        w_new;
  logic [255:0] round_out;

  // w_q[0] always holds Wj for the current round; the window slides by one.
  assign w_new = p1(w_q[0] ^ w_q[7] ^ rotl32(w_q[13], 5'd15))
               ^ rotl32(w_q[3], 5'd7) ^ w_q[10];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_win
      assign w_load[gi] = b_in[511-32*gi -: 32];
      if (gi < 15) begin : g_mid
        assign w_shift[gi] = w_q[gi+1];
      end else begin : g_top
        assign w_shift[gi] = w_new;
      end
    end
  endgenerate

  sm3_round u_round (
    .state_in  (abcd_q),
    .w_j       (w_q[0]),
    .w_j4      (w_q[4]),
    .j         (cnt_q),
    .state_out (round_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    v_d      = v_q;
    abcd_d   = abcd_q;
    w_d      = w_q;
    v_out_d  = v_out_q;
    cf_end_d = cf_end_q;
    case (state_q)
      IDLE: begin
        if (cf_start) begin
          v_d     = v_in;
          abcd_d  = v_in;
          w_d     = w_load;
          cnt_d   = 6'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        abcd_d = round_out;
        w_d    = w_shift;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'(ROUNDS - 1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        v_out_d  = abcd_q ^ v_q;
        cf_end_d = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        // A held request never restarts; the initiator must drop it first.
        if (!cf_start) begin
          cf_end_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      v_q      <= '0;
      abcd_q   <= '0;
      v_out_q  <= '0;
      cf_end_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      v_q      <= v_d;
      abcd_q   <= abcd_d;
      v_out_q  <= v_out_d;
      cf_end_q <= cf_end_d;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign v_out  = v_out_q;
  assign cf_end = cf_end_q;

endmodule

// File: tb/tb_sm3_cf_iter.sv
// Self-checking bench for sm3_cf_iter: table of known SM3 blocks plus
// handshake, input-mutation, mid-run reset and early-drop sequences.
module tb_sm3_cf_iter;

  localparam logic [255:0] IV = {
    32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
    32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e
  };
  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_ABCD  = {16{32'h61626364}};
  localparam logic [511:0] BLK_PAD2  = {32'h80000000, {14{32'h0}}, 32'h00000200};
  localparam logic [255:0] EXP_ABC   =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] EXP_EMPTY =
    256'h1ab21d83_55cfa17f_8e611948_31e81a8f_22bec8c7_28fefb74_7ed035eb_5082aa2b;
  localparam logic [255:0] EXP_ABCD  =
    256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
  localparam int LATENCY = 65;
  localparam int NO_DROP = -1;

  logic         clk = 1'b0;
  logic         reset;
  logic         cf_start;
  logic [255:0] v_in;
  logic [511:0] b_in;
  logic [255:0] v_out;
  logic         cf_end;

  int n_pass  = 0;
  int n_total = 0;
  logic [255:0] exp_q [$];

  typedef struct {
    string        name;
    logic [255:0] v;
    logic [511:0] b;
    bit           chain;
    bit           chk;
    logic [255:0] want;
  } vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;

  sm3_cf_iter dut (
    .clk      (clk),
    .reset    (reset),
    .cf_start (cf_start),
    .v_in     (v_in),
    .b_in     (b_in),
    .v_out    (v_out),
    .cf_end   (cf_end)
  );

  task automatic check_vec(input string name, input logic [255:0] got, input logic [255:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b want %b", name, got, want);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Raise a request, wait (bounded) for cf_end; lat counts edges after E0.
  task automatic run_cf(input logic [255:0] v, input logic [511:0] b, input bit mutate,
                        input int drop_at, output int lat, output logic [255:0] res);
    @(negedge clk);
    v_in = v;
    b_in = b;
    cf_start = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    while (!cf_end && lat < 200) begin
      if (mutate) begin
        v_in = rand512()[255:0];
        b_in = rand512();
      end
      if (lat == drop_at) cf_start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    res = v_out;
  endtask

  task automatic run_scored(input string name, input logic [255:0] v, input logic [511:0] b,
                            input bit mutate, input int drop_at, input bit chk,
                            input logic [255:0] want, output logic [255:0] res);
    int lat;
    logic [255:0] exp_v;
    if (chk) exp_q.push_back(want);
    run_cf(v, b, mutate, drop_at, lat, res);
    check_int({name, "_latency"}, lat, LATENCY);
    if (chk) begin
      exp_v = exp_q.pop_front();
      check_vec({name, "_v_out"}, res, exp_v);
    end
  endtask

  task automatic release_start(input string name, input logic [255:0] hold_v);
    cf_start = 1'b0;
    @(posedge clk);
    #1;
    check_bit({name, "_cf_end_clear"}, cf_end, 1'b0);
    check_vec({name, "_v_out_held"}, v_out, hold_v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] prev;
    logic [255:0] res;
    logic [255:0] v_use;

    tbl[0] = '{"abc",     IV, BLK_ABC,   1'b0, 1'b1, EXP_ABC};
    tbl[1] = '{"empty",   IV, BLK_EMPTY, 1'b0, 1'b1, EXP_EMPTY};
    tbl[2] = '{"abcd_b1", IV, BLK_ABCD,  1'b0, 1'b0, '0};
    tbl[3] = '{"abcd_b2", '0, BLK_PAD2,  1'b1, 1'b1, EXP_ABCD};

    reset = 1'b0;
    cf_start = 1'b0;
    v_in = '0;
    b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_v_out", v_out, '0);
    check_bit("reset_cf_end", cf_end, 1'b0);
    reset = 1'b1;

    prev = '0;
    for (int i = 0; i < 4; i++) begin
      v_use = tbl[i].chain ? prev : tbl[i].v;
      run_scored(tbl[i].name, v_use, tbl[i].b, 1'b0, NO_DROP, tbl[i].chk, tbl[i].want, res);
      $display("vector %s: v_out=%h", tbl[i].name, res);
      prev = res;
      release_start(tbl[i].name, res);
    end

    // Held request after completion: cf_end stays, result stable, no restart.
    run_scored("hold", IV, BLK_ABC, 1'b0, NO_DROP, 1'b1, EXP_ABC, res);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check_bit("hold_cf_end", cf_end, 1'b1);
      check_vec("hold_v_out", v_out, EXP_ABC);
    end
    release_start("hold", EXP_ABC);
    run_scored("rerun", IV, BLK_ABC, 1'b0, NO_DROP, 1'b1, EXP_ABC, res);
    release_start("rerun", EXP_ABC);

    // Inputs scrambled on every edge after E0.
    run_scored("mutate", IV, BLK_ABC, 1'b1, NO_DROP, 1'b1, EXP_ABC, res);
    release_start("mutate", EXP_ABC);

    // Reset during round 30 clears outputs with no partial result.
    @(negedge clk);
    v_in = IV;
    b_in = BLK_ABC;
    cf_start = 1'b1;
    @(posedge clk);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_vec("midreset_v_out", v_out, '0);
    check_bit("midreset_cf_end", cf_end, 1'b0);
    reset = 1'b1;
    cf_start = 1'b0;
    @(posedge clk);
    #1;
    check_bit("post_reset_idle_cf_end", cf_end, 1'b0);
    check_vec("post_reset_idle_v_out", v_out, '0);
    run_scored("after_reset", IV, BLK_ABC, 1'b0, NO_DROP, 1'b1, EXP_ABC, res);
    release_start("after_reset", EXP_ABC);

    // Request dropped at round 10: single-cycle cf_end pulse.
    run_scored("early_drop", IV, BLK_ABC, 1'b0, 10, 1'b1, EXP_ABC, res);
    @(posedge clk);
    #1;
    check_bit("early_drop_pulse_end", cf_end, 1'b0);
    check_vec("early_drop_v_out_held", v_out, EXP_ABC);
    @(posedge clk);
    #1;
    check_bit("early_drop_idle", cf_end, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
